// File: rtl/coord_pkg.sv
// Shared types, default sizes and bound helpers for the coordinate stream
// generator and its counters.
package coord_pkg;

    localparam int DEF_X_SIZE = 640;
    localparam int DEF_Y_SIZE = 480;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int calc_x_min(input int x_size);
        return -(x_size / 2);
    endfunction

    function automatic int calc_x_last(input int x_size, input int ppc);
        return (x_size / 2) - ppc;
    endfunction

    function automatic int calc_y_max(input int y_size);
        return y_size / 2;
    endfunction

    function automatic int calc_y_min(input int y_size);
        return 1 - (y_size / 2);
    endfunction

    function automatic bit fits_signed(input int v, input int w);
        return (v >= -(1 << (w - 1))) && (v <= (1 << (w - 1)) - 1);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Signed counter: steps by STEP when enabled, reloads LOAD after reaching TERM.
module wrap_counter #(
    parameter int W    = 8,
    parameter int LOAD = 0,
    parameter int STEP = 1,
    parameter int TERM = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    output logic signed [W-1:0] value,
    output logic                tc
);

    localparam logic signed [W-1:0] LOAD_V = W'(LOAD);
    localparam logic signed [W-1:0] STEP_V = W'(STEP);
    localparam logic signed [W-1:0] TERM_V = W'(TERM);

    assign tc = (value == TERM_V);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            value <= LOAD_V;
        end else if (en) begin
            value <= tc ? LOAD_V : value + STEP_V;
        end
    end

endmodule

// File: rtl/coord_stream_gen.sv
// Origin-centred raster coordinate source over a valid/ready stream.
// Optional completed-frame counter enabled by COORD_STREAM_GEN_FCNT_EN.
module coord_stream_gen
    import coord_pkg::*;
#(
    parameter int X_SIZE = DEF_X_SIZE,
    parameter int Y_SIZE = DEF_Y_SIZE,
    parameter int XW     = 10,
    parameter int YW     = 9,
    parameter int PPC    = 1,
    parameter int FCW    = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 run,
    input  logic                 ready,
    output logic                 valid,
    output logic signed [XW-1:0] x,
    output logic signed [YW-1:0] y,
    output logic                 first,
    output logic                 lastx,
    output logic                 lastf,
    output logic                 busy
`ifdef COORD_STREAM_GEN_FCNT_EN
    ,
    output logic [FCW-1:0]       frame_cnt
`endif
);

    localparam int X_MIN  = calc_x_min(X_SIZE);
    localparam int X_LAST = calc_x_last(X_SIZE, PPC);
    localparam int Y_MAX  = calc_y_max(Y_SIZE);
    localparam int Y_MIN  = calc_y_min(Y_SIZE);

    localparam logic signed [XW-1:0] X_MIN_V = XW'(X_MIN);
    localparam logic signed [YW-1:0] Y_MAX_V = YW'(Y_MAX);

    if ((X_SIZE % PPC) != 0 || (X_SIZE % 2) != 0 || (Y_SIZE % 2) != 0 ||
        !(PPC == 1 || PPC == 2 || PPC == 4) || FCW < 1 ||
        !fits_signed(X_MIN, XW) || !fits_signed(X_LAST, XW) ||
        !fits_signed(Y_MAX, YW) || !fits_signed(Y_MIN, YW)) begin : g_bad_cfg
        $error("coord_stream_gen: illegal size/PPC/width combination");
    end

    state_t state_q, state_d;
    logic   handshake;
    logic   frame_done;
    logic   x_tc;
    logic   y_tc;

    assign valid      = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign handshake  = valid && ready;
    assign first      = valid && (x == X_MIN_V) && (y == Y_MAX_V);
    assign lastx      = valid && x_tc;
    assign lastf      = lastx && y_tc;
    assign frame_done = handshake && lastf;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // run only matters at frame boundaries; a started frame always finishes.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (run) state_d = RUN;
            RUN:     if (frame_done && !run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    wrap_counter #(
        .W   (XW),
        .LOAD(X_MIN),
        .STEP(PPC),
        .TERM(X_LAST)
    ) u_x_cnt (
        .clk   (clk),
        .resetn(resetn),
        .en    (handshake),
        .value (x),
        .tc    (x_tc)
    );

    // y steps down once per line, wrapping back to the top after the last line.
    wrap_counter #(
        .W   (YW),
        .LOAD(Y_MAX),
        .STEP(-1),
        .TERM(Y_MIN)
    ) u_y_cnt (
        .clk   (clk),
        .resetn(resetn),
        .en    (handshake && x_tc),
        .value (y),
        .tc    (y_tc)
    );

`ifdef COORD_STREAM_GEN_FCNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + FCW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_coord_stream_gen.sv
// Directed bench for coord_stream_gen: 8x4 PPC=2 instance plus a default-size instance.
module tb_coord_stream_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn, run, ready;
    logic              valid, first, lastx, lastf, busy;
    logic signed [3:0] x;
    logic signed [2:0] y;

    logic              run2, ready2;
    logic              valid2, first2, lastx2, lastf2, busy2;
    logic signed [9:0] x2;
    logic signed [8:0] y2;
`ifdef COORD_STREAM_GEN_FCNT_EN
    logic [15:0] frame_cnt, frame_cnt2;
`endif

    coord_stream_gen #(
        .X_SIZE(8), .Y_SIZE(4), .XW(4), .YW(3), .PPC(2), .FCW(16)
    ) dut (
        .clk(clk), .resetn(resetn), .run(run), .ready(ready),
        .valid(valid), .x(x), .y(y), .first(first), .lastx(lastx),
        .lastf(lastf), .busy(busy)
`ifdef COORD_STREAM_GEN_FCNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    coord_stream_gen u_def (
        .clk(clk), .resetn(resetn), .run(run2), .ready(ready2),
        .valid(valid2), .x(x2), .y(y2), .first(first2), .lastx(lastx2),
        .lastf(lastf2), .busy(busy2)
`ifdef COORD_STREAM_GEN_FCNT_EN
        , .frame_cnt(frame_cnt2)
`endif
    );

    typedef struct {
        logic run;
        logic rdy;
        logic valid;
        int   x;
        int   y;
        logic first;
        logic lastx;
        logic lastf;
        logic busy;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    // Beat order of one 8x4 PPC=2 frame.
    int   fx[16] = '{-4, -2, 0, 2, -4, -2, 0, 2, -4, -2, 0, 2, -4, -2, 0, 2};
    int   fy[16] = '{ 2,  2, 2, 2,  1,  1, 1, 1,  0,  0, 0, 0, -1, -1, -1, -1};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input int ex, input int ey,
                           input logic f, input logic lx, input logic lf, input logic b);
        check({tag, ".valid"}, int'(valid), int'(v));
        check({tag, ".x"},     int'(x),     ex);
        check({tag, ".y"},     int'(y),     ey);
        check({tag, ".first"}, int'(first), int'(f));
        check({tag, ".lastx"}, int'(lastx), int'(lx));
        check({tag, ".lastf"}, int'(lastf), int'(lf));
        check({tag, ".busy"},  int'(busy),  int'(b));
    endtask

    task automatic chk_beat(input string tag, input int k);
        chk_out(tag, 1'b1, fx[k], fy[k], k == 0, fx[k] == 2, k == 15, 1'b1);
    endtask

    task automatic chk_idle(input string tag);
        chk_out(tag, 1'b0, -4, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic vec_t row(input logic r, input logic rd, input logic v, input int ex,
                                 input int ey, input logic f, input logic lx, input logic lf,
                                 input logic b);
        vec_t t;
        t.run = r; t.rdy = rd; t.valid = v; t.x = ex; t.y = ey;
        t.first = f; t.lastx = lx; t.lastf = lf; t.busy = b;
        return t;
    endfunction

    initial begin
        int hs_cnt;
        int cyc;
        int k;

        // run, rdy | valid, x, y, first, lastx, lastf, busy
        tbl.push_back(row(1, 1, 0, -4,  2, 0, 0, 0, 0));  // idle, run just raised
        tbl.push_back(row(1, 1, 1, -4,  2, 1, 0, 0, 1));  // frame 1
        tbl.push_back(row(1, 1, 1, -2,  2, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1,  0,  2, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1,  2,  2, 0, 1, 0, 1));
        tbl.push_back(row(1, 1, 1, -4,  1, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1, -2,  1, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1,  0,  1, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1,  2,  1, 0, 1, 0, 1));
        tbl.push_back(row(1, 1, 1, -4,  0, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1, -2,  0, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1,  0,  0, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1,  2,  0, 0, 1, 0, 1));
        tbl.push_back(row(1, 1, 1, -4, -1, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1, -2, -1, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1,  0, -1, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1,  2, -1, 0, 1, 1, 1));
        tbl.push_back(row(1, 1, 1, -4,  2, 1, 0, 0, 1));  // frame 2, no bubble
        tbl.push_back(row(1, 1, 1, -2,  2, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1,  0,  2, 0, 0, 0, 1));
        tbl.push_back(row(1, 1, 1,  2,  2, 0, 1, 0, 1));
        tbl.push_back(row(0, 1, 1, -4,  1, 0, 0, 0, 1));  // run dropped on 5th handshake
        tbl.push_back(row(0, 1, 1, -2,  1, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1,  0,  1, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1,  2,  1, 0, 1, 0, 1));
        tbl.push_back(row(0, 1, 1, -4,  0, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1, -2,  0, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1,  0,  0, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1,  2,  0, 0, 1, 0, 1));
        tbl.push_back(row(0, 1, 1, -4, -1, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1, -2, -1, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1,  0, -1, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1,  2, -1, 0, 1, 1, 1));
        tbl.push_back(row(0, 1, 0, -4,  2, 0, 0, 0, 0));  // back in IDLE
        tbl.push_back(row(0, 1, 0, -4,  2, 0, 0, 0, 0));
        tbl.push_back(row(1, 0, 0, -4,  2, 0, 0, 0, 0));  // re-assert run
        tbl.push_back(row(1, 0, 1, -4,  2, 1, 0, 0, 1));  // fresh frame, stalled
        tbl.push_back(row(1, 0, 1, -4,  2, 1, 0, 0, 1));

        resetn = 1'b0; run = 1'b0; ready = 1'b0;
        run2 = 1'b0; ready2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
`ifdef COORD_STREAM_GEN_FCNT_EN
        check("reset.frame_cnt", int'(frame_cnt), 0);
`endif
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            run   = tbl[i].run;
            ready = tbl[i].rdy;
            chk_out($sformatf("tbl[%0d]", i), tbl[i].valid, tbl[i].x, tbl[i].y,
                    tbl[i].first, tbl[i].lastx, tbl[i].lastf, tbl[i].busy);
            @(negedge clk);
        end
`ifdef COORD_STREAM_GEN_FCNT_EN
        check("tbl.frame_cnt", int'(frame_cnt), 2);
`endif

        // Random back-pressure: two full frames, outputs held while stalled.
        hs_cnt = 0;
        cyc    = 0;
        run    = 1'b1;
        while (hs_cnt < 32 && cyc < 400) begin
            ready = 1'($urandom_range(0, 1));
            chk_beat($sformatf("rand[%0d]", hs_cnt), hs_cnt % 16);
            if (ready) hs_cnt++;
            cyc++;
            @(negedge clk);
        end
        check("rand.handshakes", hs_cnt, 32);

        // Drop run exactly on the lastf handshake.
        ready = 1'b1;
        for (k = 0; k < 16; k++) begin
            run = (k != 15);
            chk_beat($sformatf("stop_on_lastf[%0d]", k), k);
            @(negedge clk);
        end
        chk_idle("after_lastf_stop");
        run   = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        chk_beat("restart", 0);

        // Reset mid-frame while stalled at (0,1).
        ready = 1'b1;
        for (k = 0; k < 6; k++) begin
            chk_beat($sformatf("pre_reset[%0d]", k), k);
            @(negedge clk);
        end
        ready = 1'b0;
        chk_beat("at_reset", 6);
        resetn = 1'b0;
        @(negedge clk);
        chk_idle("mid_reset");
        resetn = 1'b1;
        run    = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // Default 640x480 PPC=1 instance: first line and start of the second.
        run2 = 1'b1;
        @(negedge clk);
        for (int n = 0; n <= 640; n++) begin
            if (n == 0) begin
                check("def.first.valid", int'(valid2), 1);
                check("def.first.x", int'(x2), -320);
                check("def.first.y", int'(y2), 240);
                check("def.first.flag", int'(first2), 1);
            end else if (n == 639) begin
                check("def.eol.x", int'(x2), 319);
                check("def.eol.y", int'(y2), 240);
                check("def.eol.lastx", int'(lastx2), 1);
                check("def.eol.lastf", int'(lastf2), 0);
                check("def.eol.first", int'(first2), 0);
            end else if (n == 640) begin
                check("def.line2.x", int'(x2), -320);
                check("def.line2.y", int'(y2), 239);
                check("def.line2.lastx", int'(lastx2), 0);
                check("def.line2.busy", int'(busy2), 1);
            end
            @(negedge clk);
        end
        run2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coord_stream_gen.md
Name: coord_stream_gen

Overview:
Parametrised successor of the raster coordinate source. Emits signed, origin-centred (x, y) pixel coordinates over a valid/ready stream, scanning left-to-right and top-to-bottom (y decreasing). Generalised resolution, multi-pixel-per-beat output, frame-level run/stop control and end-of-line/end-of-frame markers. Feeds the per-pixel compute pipeline, ahead of the video output path.

Parameters:
X_SIZE, 640, active width in pixels; even, divisible by PPC.
Y_SIZE, 480, active height in lines; even.
XW, 10, signed x width; must hold -X_SIZE/2 .. X_SIZE/2-1.
YW, 9, signed y width; must hold 1-Y_SIZE/2 .. Y_SIZE/2.
PPC, 1, pixels per beat (1, 2 or 4); x is the leftmost pixel of the beat.
FCW, 16, frame counter width (optional feature only).

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
run  in  1  frame enable; sampled at frame boundaries
ready  in  1  downstream accepts the current beat
valid  out  1  beat present
x  out  XW  signed x of the leftmost pixel in the beat
y  out  YW  signed y of the line
first  out  1  first beat of frame (x_min, y_max)
lastx  out  1  last beat of line
lastf  out  1  last beat of frame (lastx && y == y_min)
busy  out  1  high in RUN
frame_cnt  out  FCW  completed-frame count (only with COORD_STREAM_GEN_FCNT_EN)

Behaviour:
- One clock, clk. Reset is synchronous and active-low (resetn), as already decided.
- Bounds: x_min = -X_SIZE/2, x_last = X_SIZE/2 - PPC, y_max = Y_SIZE/2, y_min = 1 - Y_SIZE/2.
- Reset: state IDLE, valid = 0, busy = 0, x = x_min, y = y_max, frame_cnt = 0.
- first, lastx and lastf are combinational from x and y, gated by valid.
- States:
  - IDLE: valid = 0. If run = 1 at a clock edge, go to RUN, with valid = 1 on the next cycle at (x_min, y_max). Start latency is 1 cycle.
  - RUN: valid = 1. On a handshake (valid && ready), advance. Otherwise x and y hold and all outputs stay stable, AXI-stream style.
- Advance rule:
  - If x != x_last: x += PPC.
  - Else: x = x_min, and y = y - 1 if y != y_min, else y wraps to y_max.
- Frame boundary (handshake on the lastf beat):
  - run = 1 on that cycle: stay in RUN. The next frame's first beat follows with no bubble.
  - run = 0 on that cycle: go to IDLE. valid = 0 next cycle; coordinates are already at (x_min, y_max).
- run changes mid-frame are ignored. A frame, once started, always completes.
- Reset mid-frame has priority over any handshake. The next cycle shows reset values.
- Arithmetic is signed at XW/YW. No overflow is possible within legal parameters.
- Elaboration error if X_SIZE % PPC != 0 or a bound does not fit XW/YW.

Optional Feature:
COORD_STREAM_GEN_FCNT_EN.
- Defined: the frame_cnt port exists and increments by 1 on each lastf handshake, wrapping modulo 2^FCW. It resets to 0.
- Undefined: no frame_cnt port and no counter logic. All other behaviour is identical.

Decomposition:
- Package coord_pkg holds:
  - bound-computation constant functions (x_min, x_last, y_min, y_max from size and PPC);
  - the IDLE/RUN state type;
  - default size constants (640, 480).
- One natural sub-module, wrap_counter: a signed counter with load value, step and terminal-count output. It is instantiated once for x (step +PPC) and once for y (step -1, enabled on the x terminal count).

Test Plan:
- X_SIZE=8, Y_SIZE=4, PPC=2; run=1, ready=1 -> valid rises 1 cycle after run. Beats: (-4,2) with first, (-2,2), (0,2), (2,2) with lastx, (-4,1) … (2,-1) with lastx and lastf. Then (-4,2) with first on the very next cycle; 16 beats per frame.
- Same config, ready driven by a random 50% pattern -> x, y and flags stay constant whenever valid && !ready; exactly 16 handshakes per frame, in the sequence above.
- Drop run at the 5th handshake -> frame completes through (2,-1). Next cycle valid=0 and busy=0 with x=-4, y=2. Re-assert run -> a fresh frame starts at (-4,2).
- Drop run exactly on the lastf handshake -> IDLE next cycle. Keep run=1 on that cycle -> continuous frames.
- Reset asserted mid-frame with valid=1 and ready=0 at (0,1) -> next cycle valid=0, x=-4, y=2, IDLE.
- Default 640x480, PPC=1 -> first beat (-320,240), last beat (319,-239) with lastf, 307200 handshakes per frame. With COORD_STREAM_GEN_FCNT_EN and FCW=2, frame_cnt reads 1, 2, 3, 0 after frames 1 to 4.
